// File: rtl/seg7_scan_ctrl.sv
// Scan controller for an 8-digit common-anode 7-segment display, with double-buffered LOAD that commits on frame boundaries.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 is always shown).
module seg7_scan_ctrl #(
  parameter int unsigned TICK_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] data_i,
  input  logic [7:0]  dp_in_i,
  input  logic [7:0]  dig_en_i,
  input  logic        load_i,
  output logic        pending_o,
  output logic        frame_o,
  output logic        ca_o,
  output logic        cb_o,
  output logic        cc_o,
  output logic        cd_o,
  output logic        ce_o,
  output logic        cf_o,
  output logic        cg_o,
  output logic        dp_o,
  output logic        an0_o,
  output logic        an1_o,
  output logic        an2_o,
  output logic        an3_o,
  output logic        an4_o,
  output logic        an5_o,
  output logic        an6_o,
  output logic        an7_o
);

  localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_MAX  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYC);

  logic [CW-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          tick, boundary;

  logic [31:0]   data_sh_q, data_act_q;
  logic [7:0]    dp_sh_q, dp_act_q;
  logic [7:0]    en_sh_q, en_act_q;
  logic          pending_q, pending_d;
  logic          frame_q;

  logic [7:0]    show_en;
  logic [3:0]    nib;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  // Segment pattern {g,f,e,d,c,b,a}, active-low
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign tick     = (tick_cnt_q == TICK_MAX);
  assign boundary = tick && (idx_q == 3'd7);

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + CW'(1);
    idx_d      = tick ? idx_q + 3'd1 : idx_q;
    pending_d  = pending_q;
    if (boundary) pending_d = 1'b0;
    // A LOAD coinciding with a commit leaves the new values waiting for the next frame
    if (load_i) pending_d = 1'b1;
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [7:0] nz_above;
  always_comb begin
    nz_above    = '0;
    nz_above[7] = |data_act_q[31:28];
    for (int k = 6; k >= 0; k--) begin
      nz_above[k] = nz_above[k+1] | (|data_act_q[4*k +: 4]);
    end
    show_en = en_act_q & {nz_above[7:1], 1'b1};
  end
`else
  assign show_en = en_act_q;
`endif

  assign nib = data_act_q[{idx_q, 2'b00} +: 4];

  always_comb begin
    an_d  = '1;
    seg_d = '1;
    dp_d  = 1'b1;
    if ((tick_cnt_q >= BLANK_LIM) && show_en[idx_q]) begin
      an_d[idx_q] = 1'b0;
      seg_d       = hex7(nib);
      dp_d        = ~dp_act_q[idx_q];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tick_cnt_q <= '0;
      idx_q      <= '0;
      data_sh_q  <= '0;
      dp_sh_q    <= '0;
      en_sh_q    <= '0;
      data_act_q <= '0;
      dp_act_q   <= '0;
      en_act_q   <= '0;
      pending_q  <= 1'b0;
      frame_q    <= 1'b0;
      an_q       <= '1;
      seg_q      <= '1;
      dp_q       <= 1'b1;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      idx_q      <= idx_d;
      pending_q  <= pending_d;
      frame_q    <= boundary;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      if (boundary && pending_q) begin
        data_act_q <= data_sh_q;
        dp_act_q   <= dp_sh_q;
        en_act_q   <= en_sh_q;
      end
      if (load_i) begin
        data_sh_q <= data_i;
        dp_sh_q   <= dp_in_i;
        en_sh_q   <= dig_en_i;
      end
    end
  end

  assign pending_o = pending_q;
  assign frame_o   = frame_q;
  assign {cg_o, cf_o, ce_o, cd_o, cc_o, cb_o, ca_o} = seg_q;
  assign dp_o      = dp_q;
  assign {an7_o, an6_o, an5_o, an4_o, an3_o, an2_o, an1_o, an0_o} = an_q;

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for the 8-digit common-anode 7-segment display (CA..CG, DP, AN0..AN7, all active-low). It shares the single segment bus among eight digits in round-robin, with one slot per prescaler tick and an anti-ghosting blank window after each digit change. Upstream logic, such as counters and measurement blocks, updates the display through a LOAD strobe. Updates are double-buffered and committed only at frame boundaries, so no frame ever mixes old and new values.

Parameters:
TICK_DIV, 100000, CLK cycles per digit slot (100 MHz gives 1 kHz per digit, 125 Hz frame rate); minimum 2.
BLANK_CYC, 4, cycles at the start of each slot with all anodes off; must be < TICK_DIV.

Ports:
CLK  in  1  system clock
RST  in  1  synchronous reset, active-high
DATA  in  32  eight hex nibbles; DATA[4k+3:4k] is digit k
DP_IN  in  8  decimal point per digit, 1 = lit
DIG_EN  in  8  digit enable mask, 1 = digit shown
LOAD  in  1  one-cycle strobe; captures DATA, DP_IN and DIG_EN into the shadow registers
PENDING  out  1  shadow holds an uncommitted update
FRAME  out  1  one-cycle pulse on the slot-7 to slot-0 transition
CA,CB,CC,CD,CE,CF,CG  out  1 each  segments, active-low
DP  out  1  decimal point, active-low
AN0..AN7  out  1 each  digit anodes, active-low

Behaviour:
- Clock and reset: single clock CLK; RST is synchronous and active-high.
- Reset values:
  - tick_cnt=0, idx=0.
  - Active and shadow data, dp and en registers all 0.
  - PENDING=0, FRAME=0.
  - All AN*=1, all segments=1, DP=1 (display dark).
- Prescaler:
  - tick_cnt counts 0..TICK_DIV-1, then wraps to 0.
  - tick asserts on the cycle where tick_cnt==TICK_DIV-1.
- Slot index:
  - idx (3 bits) increments on tick; 7 wraps to 0.
  - The 7->0 advance is the frame boundary.
  - FRAME=1 for exactly the cycle after the boundary tick; 0 otherwise.
- Commit:
  - On a boundary tick with PENDING=1, shadow copies to active and PENDING clears.
  - Without PENDING, active registers are unchanged.
- LOAD:
  - On LOAD, shadow is loaded and PENDING is set on the next edge.
  - LOAD while PENDING: shadow is overwritten, last write wins.
  - LOAD on a boundary-tick cycle: the previous shadow commits. The new values land in shadow and PENDING stays 1 until the next boundary.
- Output stage (all outputs registered, 1-cycle latency from idx/tick_cnt):
  - Blank window: when tick_cnt < BLANK_CYC, all AN*=1. Segment and DP values are don't-care but driven to 1.
  - Otherwise, when active_en[idx]=1: AN[idx]=0, all other AN=1, segments = hex pattern of active nibble idx, DP = ~active_dp[idx].
  - Disabled digit: all AN=1. The slot still consumes its full TICK_DIV cycles; there is no skipping.
- Hex decode {CG..CA}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- At most one AN is low in any cycle.
- RST mid-frame: everything returns to reset values on the next edge, any pending update is discarded, and scanning resumes at slot 0 with tick_cnt=0.

Optional Feature:
Macro SEG7_LEADING_ZERO_BLANK_EN.
- Defined:
  - Digit k (k≥1) is suppressed when active nibbles k..7 are all zero. Suppression is computed from active data only.
  - Digit 0 is never suppressed.
  - A suppressed digit behaves exactly as if its DIG_EN bit were 0; its DP is also dark.
- Undefined: every enabled digit shows its nibble, including leading zeros.

Test Plan (TICK_DIV=4, BLANK_CYC=1):
1. Reset scan: after RST, with no LOAD → AN*=1 and segments all 1 for 64 cycles. FRAME pulses every 32 cycles.
2. Basic scan: LOAD DATA=32'h76543210, DP_IN=8'h01, DIG_EN=8'hFF; wait for commit.
   - Slot k shows the segment pattern for k, with AN[k]=0 for 3 cycles and all AN high for 1 blank cycle.
   - Slot 0 shows DP=0; other slots show DP=1.
3. Tear-free update: LOAD 32'h11111111 mid-frame → PENDING=1; the current frame still shows 76543210. The new value appears from slot 0 after FRAME, and PENDING returns to 0.
4. Collision: LOAD A (8'hAA..) then LOAD B on the boundary-tick cycle → the next frame shows A, PENDING=1, and the frame after shows B.
5. Mask: DIG_EN=8'b00000101, DATA=32'h0000F0E0 → only AN0 ("0") and AN2 ("0") ever go low. Slots 1 and 3..7 stay dark for their full 4 cycles.
6. Optional feature: with SEG7_LEADING_ZERO_BLANK_EN, DATA=32'h00000305, DIG_EN=8'hFF → only digits 0..2 light ("5","0","3"). Without the macro, all 8 digits light.
